// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs RV32I fields and a signed immediate into an instruction word.
// Stage 1 registers the fields with a range/alignment verdict, stage 2 packs the word.
module imm_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [6:0] OP_IMM = 7'b0010011, LOAD = 7'b0000011, JALR = 7'b1100111,
                         STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         LUI = 7'b0110111, AUIPC = 7'b0010111, OP = 7'b0110011;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        r_s1_v, r_s1_err;
  logic [6:0]  r_op, r_f7;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [2:0]  r_f3;
  logic [31:0] r_imm;
  logic        w_i_ok, w_b_ok, w_j_ok, w_err, w_s2_adv;
  logic [31:0] w_pack;
  // A value fits in N signed bits when every bit above bit N-2 equals the sign bit.
  assign w_i_ok   = &in_imm[31:11] | ~|in_imm[31:11];
  assign w_b_ok   = (&in_imm[31:12] | ~|in_imm[31:12]) & ~in_imm[0];
  assign w_j_ok   = (&in_imm[31:20] | ~|in_imm[31:20]) & ~in_imm[0];
  assign w_s2_adv = !out_valid | out_ready;
  assign in_ready = !r_s1_v | w_s2_adv;
  always_comb begin
    w_err = (in_opcode == OP_IMM || in_opcode == LOAD || in_opcode == JALR ||
             in_opcode == STORE) ? !w_i_ok :
            (in_opcode == BRANCH) ? !w_b_ok :
            (in_opcode == JAL) ? !w_j_ok :
            (in_opcode == LUI || in_opcode == AUIPC) ? |in_imm[11:0] :
            (in_opcode == OP) ? 1'b0 : 1'b1;
  end
  // Unsupported opcodes are already flagged, so the I-type layout serves as the fallback.
  always_comb begin
    w_pack = r_s1_err ? NOP :
             (r_op == OP) ? {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op} :
             (r_op == STORE) ? {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op} :
             (r_op == BRANCH) ? {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3, r_imm[4:1],
                                 r_imm[11], r_op} :
             (r_op == JAL) ? {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op} :
             (r_op == LUI || r_op == AUIPC) ? {r_imm[31:12], r_rd, r_op} :
             {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_op     <= in_opcode;
      r_rd     <= in_rd;
      r_rs1    <= in_rs1;
      r_rs2    <= in_rs2;
      r_f3     <= in_funct3;
      r_f7     <= in_funct7;
      r_imm    <= in_imm;
      r_s1_err <= w_err;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (in_ready) r_s1_v <= in_valid;
      if (w_s2_adv) begin
        out_valid <= r_s1_v;
        if (r_s1_v) begin
          out_instr <= w_pack;
          out_err   <= r_s1_err;
        end
      end
      if (out_valid && out_ready) begin
        if (!(&enc_count)) enc_count <= enc_count + CNT_W'(1);
        if (out_err && !(&err_count)) err_count <= err_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb_imm_instr_encoder: scoreboard bench with an ISA-level encoder model and an immediate re-decoder.
module tb_imm_instr_encoder;
  localparam int CW = 4;
  typedef struct {
    logic [31:0] w;
    logic        e;
    logic [6:0]  op;
    logic [31:0] imm;
  } exp_t;
  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_err;
  logic [6:0]    in_opcode = '0, in_funct7 = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [31:0]   in_imm = '0, out_instr;
  logic [CW-1:0] enc_count, err_count;
  int checks = 0, failures = 0, exp_enc = 0, exp_err = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  imm_instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Reference encoder: legality from signed arithmetic, bit placement from the RV32I formats.
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
    exp_t r;
    int v;
    logic ok;
    logic [31:0] w;
    v = $signed(imm);
    case (op)
      7'h13, 7'h03, 7'h67: begin ok = v >= -2048 && v <= 2047; w = {imm[11:0], rs1, f3, rd, op}; end
      7'h23: begin ok = v >= -2048 && v <= 2047; w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      7'h63: begin
        ok = v >= -4096 && v <= 4094 && v % 2 == 0;
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'h6F: begin
        ok = v >= -1048576 && v <= 1048574 && v % 2 == 0;
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      7'h37, 7'h17: begin ok = v % 4096 == 0; w = {imm[31:12], rd, op}; end
      7'h33: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
      default: begin ok = 1'b0; w = '0; end
    endcase
    r.w = ok ? w : 32'h00000013;
    r.e = !ok;
    r.op = op;
    r.imm = imm;
    return r;
  endfunction
  // Immediate generator: recovers the immediate from a packed word.
  function automatic int dec(input logic [31:0] w);
    int r;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: r = $signed(w[31:20]);
      7'h23: r = $signed({w[31:25], w[11:7]});
      7'h63: r = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      7'h6F: r = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: r = {w[31:12], 12'b0};
    endcase
    return r;
  endfunction
  task automatic set_f(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_funct7 = 7'h00;
  endtask
  // One cycle: called at the falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || out_ready});
    if (out_valid && q.size() == 0) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("out_instr", out_instr, e.w);
      chk("out_err", {31'b0, out_err}, {31'b0, e.e});
      if (!e.e && e.op != 7'h33) chk("redecode_imm", dec(out_instr), e.imm);
      if (exp_enc < (1 << CW) - 1) exp_enc++;
      if (e.e && exp_err < (1 << CW) - 1) exp_err++;
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    @(posedge clk);
    #1;
    chk("enc_count", 32'(enc_count), exp_enc);
    chk("err_count", 32'(err_count), exp_err);
    @(negedge clk);
  endtask
  task automatic drain();
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) step(a);
    chk("drain_empty", q.size(), 0);
  endtask
  function automatic logic [31:0] rand_imm();
    int b[15] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097, 4096,
                  -1048576, 1048574, 1048576, -1048578, 0, 1};
    case ($urandom % 6)
      0: return b[$urandom % 15];
      1: return $urandom;
      2: return $urandom & 32'hFFFFF000;
      3: return ($urandom_range(0, 2097151) - 1048576) & ~1;
      default: return $urandom_range(0, 8191) - 4096;
    endcase
  endfunction
  initial begin
    bit a;
    int k;
    logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h00};
    chk("pin_addi", model(7'h13, 1, 0, 0, 0, 0, 5).w, 32'h00500093);
    chk("pin_sw", model(7'h23, 0, 1, 2, 3'b010, 0, 8).w, 32'h0020A423);
    chk("pin_beq", model(7'h63, 0, 1, 2, 0, 0, 8).w, 32'h00208463);
    chk("pin_jal", model(7'h6F, 1, 0, 0, 0, 0, 2048).w, 32'h001000EF);
    chk("pin_lui", model(7'h37, 5, 0, 0, 0, 0, 32'h12345000).w, 32'h123452B7);
    chk("pin_beq_odd", {31'b0, model(7'h63, 0, 1, 2, 0, 0, 3).e}, 32'd1);
    chk("pin_addi_range", {31'b0, model(7'h13, 1, 0, 0, 0, 0, 2048).e}, 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    set_f(7'h13, 1, 0, 0, 0, 5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step(a);
    in_valid = 1'b0;
    chk("latency_edge1", {31'b0, out_valid}, 32'd0);
    step(a);
    chk("latency_edge2", {31'b0, out_valid}, 32'd1);
    chk("addi_literal", out_instr, 32'h00500093);
    step(a);
    in_valid = 1'b1;
    set_f(7'h23, 0, 1, 2, 3'b010, 8); step(a);
    set_f(7'h63, 0, 1, 2, 3'b000, 8); step(a);
    set_f(7'h6F, 1, 0, 0, 3'b000, 2048); step(a);
    set_f(7'h37, 5, 0, 0, 3'b000, 32'h12345000); step(a);
    set_f(7'h63, 0, 1, 2, 3'b000, 3); step(a);
    set_f(7'h13, 1, 0, 0, 3'b000, 2048); step(a);
    set_f(7'h00, 1, 0, 0, 3'b000, 0); step(a);
    drain();
    chk("err_count_three", 32'(err_count), 32'd3);
    k = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_f(7'h13, 5'(k + 1), 0, 0, 0, k);
      step(a);
      if (a) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 4; c++) begin
      set_f(7'h13, 5'(k + 1), 0, 0, 0, k);
      step(a);
      if (a) k++;
    end
    chk("bp_all_sent", k, 4);
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_f(7'h13, 7, 0, 0, 0, 1); step(a);
    set_f(7'h13, 8, 0, 0, 0, 2); step(a);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_enc_count", 32'(enc_count), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    q.delete();
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) step(a);
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      set_f(ops[$urandom % 10], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rand_imm());
      if (in_opcode == 7'h00) in_opcode = 7'($urandom);
      in_funct7 = 7'($urandom);
      step(a);
    end
    drain();
    chk("enc_saturated", 32'(enc_count), 32'd15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
